pkt_rx_port: RTL and testbench

//  Inbound end of the byte-serial free/put/payload link: receives the 4 bytes of one pkt_t

---
 rtl/pkt_rx_port_pkg.sv | 15 +
 rtl/pkt_rx_port_fifo.sv | 53 +++++
 rtl/pkt_rx_port.sv | 108 ++++++++++
 tb/tb_pkt_rx_port.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/pkt_rx_port_pkg.sv
// Shared types for the router receive port: the 32-bit packet, its on-link
// byte count and the receive byte-sequencer states.
package pkt_rx_port_pkg;

  localparam int PKT_BYTES = 4;

  typedef struct packed {
    logic [3:0]  src;
    logic [3:0]  dest;
    logic [23:0] data;
  } pkt_t;

  typedef enum logic [1:0] {IDLE, B1, B2, B3} rx_state_t;

endpackage

// File: rtl/pkt_rx_port_fifo.sv
// Packet receive queue: wrapping read/write pointers plus an occupancy count
// 0..DEPTH. The head entry is presented combinationally and reads as zero
// while the queue is empty, so the storage itself needs no reset.
module pkt_rx_port_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [31:0]
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wr_en,
  input  T                       wr_data,
  input  logic                   rd_en,
  output T                       head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int              AW   = $clog2(DEPTH);
  localparam logic [AW:0]     FULL = (AW+1)'(DEPTH);

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Packet storage: written at the tail, never cleared.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves count alone.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // The slot reservation made at byte0 means a push into a full queue is a design bug.
  always_ff @(posedge clock) begin
    if (!reset && wr_en && !rd_en) assert (count != FULL);
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/pkt_rx_port.sv
// Inbound end of the byte-serial free/put/payload link. Reassembles four link
// bytes into a pkt_t, queues it for the router core and drives free_inbound
// back to the sender, reserving a queue slot as soon as byte0 is accepted.
// Build option PKT_RX_ABORT_EN: a missing byte mid-packet aborts the packet and
// an overrun byte is flagged, both via a one-cycle framing_err pulse. Without
// it a mid-packet gap simply stalls and framing_err is tied low.
module pkt_rx_port
  import pkt_rx_port_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        put_inbound,
  input  logic [7:0]  payload_inbound,
  output logic        free_inbound,
  output logic [31:0] pkt_out,
  output logic        pkt_avail,
  input  logic        pkt_read,
  output logic        framing_err
);

  localparam int              CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
  localparam int              SHW     = (PKT_BYTES - 1) * 8;

  rx_state_t      state;
  logic [SHW-1:0] shreg;
  logic           accept0;
  logic           wr_en;
  logic           rd_en;
  logic           reserved_next;
  logic [CW-1:0]  count;
  logic [CW-1:0]  count_next;
  pkt_t           head;
`ifdef PKT_RX_ABORT_EN
  logic           abort;
  logic           overrun;
`endif

  // Per-cycle link events and the occupancy the free flag must reflect next cycle.
  always_comb begin
    accept0       = (state == IDLE) && put_inbound && free_inbound;
    wr_en         = (state == B3) && put_inbound;
    rd_en         = pkt_read && pkt_avail;
`ifdef PKT_RX_ABORT_EN
    abort         = (state != IDLE) && !put_inbound;
    overrun       = (state == IDLE) && put_inbound && !free_inbound;
    reserved_next = accept0 || ((state != IDLE) && !wr_en && !abort);
`else
    reserved_next = accept0 || ((state != IDLE) && !wr_en);
`endif
    count_next    = count + CW'(wr_en) - CW'(rd_en);
  end

  // Byte sequencer with registered free/framing flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      free_inbound <= 1'b0;
`ifdef PKT_RX_ABORT_EN
      framing_err  <= 1'b0;
`endif
    end else begin
      free_inbound <= (count_next + CW'(reserved_next)) < DEPTH_C;
`ifdef PKT_RX_ABORT_EN
      framing_err  <= abort || overrun;
`endif
      case (state)
        IDLE:    if (accept0) state <= B1;
`ifdef PKT_RX_ABORT_EN
        B1:      state <= put_inbound ? B2 : IDLE;
        B2:      state <= put_inbound ? B3 : IDLE;
        B3:      state <= IDLE;
`else
        B1:      if (put_inbound) state <= B2;
        B2:      if (put_inbound) state <= B3;
        B3:      if (put_inbound) state <= IDLE;
`endif
        default: state <= IDLE;
      endcase
    end
  end

  // Header and data bytes shift in ahead of byte3; stale bits fall off the top.
  always_ff @(posedge clock) begin
    if (accept0 || (put_inbound && (state == B1 || state == B2)))
      shreg <= {shreg[SHW-9:0], payload_inbound};
  end

`ifndef PKT_RX_ABORT_EN
  assign framing_err = 1'b0;
`endif

  pkt_rx_port_fifo #(.DEPTH(DEPTH), .T(pkt_t)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (pkt_t'({shreg, payload_inbound})),
    .rd_en   (rd_en),
    .head    (head),
    .count   (count)
  );

  assign pkt_out   = head;
  assign pkt_avail = (count != '0);

endmodule

// File: tb/tb_pkt_rx_port.sv
// Directed bench for pkt_rx_port: reset state, single packet, queue fill and
// flow control, read/write collision, overrun, mid-packet gap, reset mid-packet.
module tb_pkt_rx_port;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        put_inbound = 1'b0;
  logic [7:0]  payload_inbound = 8'h00;
  logic        free_inbound;
  logic [31:0] pkt_out;
  logic        pkt_avail;
  logic        pkt_read = 1'b0;
  logic        framing_err;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  pkt_rx_port #(.DEPTH(4)) dut (
    .clock           (clk),
    .reset           (reset),
    .put_inbound     (put_inbound),
    .payload_inbound (payload_inbound),
    .free_inbound    (free_inbound),
    .pkt_out         (pkt_out),
    .pkt_avail       (pkt_avail),
    .pkt_read        (pkt_read),
    .framing_err     (framing_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    put_inbound     = 1'b1;
    payload_inbound = b;
    tick();
    put_inbound     = 1'b0;
  endtask

  task automatic send_pkt(input logic [31:0] p);
    send_byte(p[31:24]);
    send_byte(p[23:16]);
    send_byte(p[15:8]);
    send_byte(p[7:0]);
  endtask

  task automatic pop();
    pkt_read = 1'b1;
    tick();
    pkt_read = 1'b0;
  endtask

  initial begin
    logic [31:0] p5;
    p5 = 32'h5E000005;

    // Reset state
    tick();
    tick();
    check("rst_free", free_inbound, 1'b0);
    check("rst_avail", pkt_avail, 1'b0);
    check("rst_pkt_out", pkt_out, 32'h0);
    check("rst_ferr", framing_err, 1'b0);
    reset = 1'b0;
    tick();
    check("post_rst_free", free_inbound, 1'b1);

    // 1: single packet
    send_byte(8'h25);
    check("t1_free_after_b0", free_inbound, 1'b1);
    check("t1_avail_mid", pkt_avail, 1'b0);
    send_byte(8'hAB);
    send_byte(8'hCD);
    send_byte(8'hEF);
    check("t1_avail", pkt_avail, 1'b1);
    check("t1_pkt", pkt_out, 32'h25ABCDEF);
    check("t1_src", {28'h0, pkt_out[31:28]}, 32'h2);
    check("t1_dest", {28'h0, pkt_out[27:24]}, 32'h5);
    pop();
    check("t1_empty", pkt_avail, 1'b0);

    // 2: fill the queue
    send_pkt(32'h1A000001);
    send_pkt(32'h2B000002);
    send_pkt(32'h3C000003);
    check("t2_free_cnt3", free_inbound, 1'b1);
    send_byte(8'h4D);
    check("t2_free_after_b0_p4", free_inbound, 1'b0);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h04);
    check("t2_free_full", free_inbound, 1'b0);
    tick();
    check("t2_free_stays", free_inbound, 1'b0);
    check("t2_head_p1", pkt_out, 32'h1A000001);
    pop();
    check("t2_free_after_read", free_inbound, 1'b1);
    check("t2_head_p2", pkt_out, 32'h2B000002);
    pop();
    check("t2_head_p3", pkt_out, 32'h3C000003);

    // 3: byte3 write collides with pkt_read at count=2
    send_byte(p5[31:24]);
    send_byte(p5[23:16]);
    send_byte(p5[15:8]);
    put_inbound     = 1'b1;
    payload_inbound = p5[7:0];
    pkt_read        = 1'b1;
    tick();
    put_inbound     = 1'b0;
    pkt_read        = 1'b0;
    check("t3_head_p4", pkt_out, 32'h4D000004);
    check("t3_free", free_inbound, 1'b1);
    pop();
    check("t3_head_p5", pkt_out, p5);
    pop();
    check("t3_empty", pkt_avail, 1'b0);

    // 4: overrun on a full queue
    send_pkt(32'h61111111);
    send_pkt(32'h72222222);
    send_pkt(32'h83333333);
    send_pkt(32'h94444444);
    check("t4_full_free", free_inbound, 1'b0);
    send_byte(8'h11);
`ifdef PKT_RX_ABORT_EN
    check("t4_ferr", framing_err, 1'b1);
`else
    check("t4_ferr", framing_err, 1'b0);
`endif
    check("t4_head", pkt_out, 32'h61111111);
    check("t4_free", free_inbound, 1'b0);
    tick();
    check("t4_ferr_drop", framing_err, 1'b0);
    pop();
    check("t4_free_read", free_inbound, 1'b1);
    send_pkt(32'hA5555555);
    check("t4_q2", pkt_out, 32'h72222222);
    pop();
    check("t4_q3", pkt_out, 32'h83333333);
    pop();
    check("t4_q4", pkt_out, 32'h94444444);
    pop();
    check("t4_q5", pkt_out, 32'hA5555555);
    pop();
    check("t4_empty", pkt_avail, 1'b0);

    // 5: two-cycle gap after byte1
    send_byte(8'h47);
    send_byte(8'h12);
    tick();
`ifdef PKT_RX_ABORT_EN
    check("t5_ferr", framing_err, 1'b1);
`else
    check("t5_ferr", framing_err, 1'b0);
`endif
    tick();
    check("t5_ferr_gap2", framing_err, 1'b0);
    check("t5_avail_gap", pkt_avail, 1'b0);
    check("t5_free_gap", free_inbound, 1'b1);
`ifndef PKT_RX_ABORT_EN
    send_byte(8'h34);
    send_byte(8'h56);
    check("t5_avail", pkt_avail, 1'b1);
    check("t5_pkt", pkt_out, 32'h47123456);
`endif

    // 6: reset after byte2
    send_byte(8'h61);
    send_byte(8'h62);
    send_byte(8'h63);
    reset = 1'b1;
    tick();
    check("t6_avail", pkt_avail, 1'b0);
    check("t6_pkt_out", pkt_out, 32'h0);
    check("t6_free", free_inbound, 1'b0);
    reset = 1'b0;
    tick();
    check("t6_free_post", free_inbound, 1'b1);
    check("t6_avail_post", pkt_avail, 1'b0);
    send_pkt(32'h9A010203);
    check("t6_avail_new", pkt_avail, 1'b1);
    check("t6_pkt_new", pkt_out, 32'h9A010203);
    pop();
    check("t6_empty", pkt_avail, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
